// File: rtl/rng_address_sched_pkg.sv
// Shared definitions for the rng_address scheduler: FSM encoding and default width.
package rng_address_sched_pkg;

    localparam int W_DEFAULT = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/rng_address_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rng_address_sched_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_vld
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
    end

endmodule

// File: rtl/rng_address_sched.sv
// Shares one repeated-subtraction reduction unit between NUM_REQ requesters,
// re-arming it per job and guarding against count==0 and runaway iteration.
module rng_address_sched
    import rng_address_sched_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int W          = W_DEFAULT,
    parameter  int MAX_CYCLES = 1024,
    localparam int ID_W       = $clog2(NUM_REQ),
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*W-1:0] req_count,
    input  logic [NUM_REQ*W-1:0] req_which,
    output logic                 resp_valid,
    output logic [ID_W-1:0]      resp_id,
    output logic [W-1:0]         resp_addr,
    output logic                 resp_err,
    output logic                 busy,
    output logic                 ru_nrst,
    output logic                 ru_start,
    output logic [W-1:0]         ru_count,
    output logic [W-1:0]         ru_which,
    input  logic [W-1:0]         ru_addr,
    input  logic                 ru_done
);

    state_t              state, state_nxt;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     id_q;
    logic                skip_q;
    logic [CNT_W-1:0]    cyc_cnt;
    logic [NUM_REQ-1:0]  req_masked;
    logic [ID_W-1:0]     grant_id;
    logic                grant_vld;
    logic [W-1:0]        grant_count;
    logic [W-1:0]        grant_which;
    logic                timeout;

    // The just-served requester may still hold req for one cycle; hide it then.
    assign req_masked  = skip_q ? (req & ~(NUM_REQ'(1) << id_q)) : req;
    assign grant_count = req_count[int'(grant_id)*W +: W];
    assign grant_which = req_which[int'(grant_id)*W +: W];
    assign timeout     = (cyc_cnt == CNT_W'(MAX_CYCLES - 1));

    assign busy     = (state != S_IDLE);
    assign ru_nrst  = !(rst || (state == S_ARM));
    assign ru_start = (state == S_LAUNCH);

    rng_address_sched_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req       (req_masked),
        .ptr       (rr_ptr),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (grant_vld) state_nxt = (grant_count == '0) ? S_DONE : S_ARM;
            S_ARM:    state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT:   if (ru_done || timeout) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            id_q       <= '0;
            skip_q     <= 1'b0;
            cyc_cnt    <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_addr  <= '0;
            resp_err   <= 1'b0;
            ru_count   <= '0;
            ru_which   <= '0;
        end else begin
            state      <= state_nxt;
            resp_valid <= 1'b0;
            skip_q     <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        id_q     <= grant_id;
                        ru_count <= grant_count;
                        ru_which <= grant_which;
                        // A zero divisor would never terminate in the unit; answer directly.
                        if (grant_count == '0) begin
                            resp_valid <= 1'b1;
                            resp_id    <= grant_id;
                            resp_addr  <= '0;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: cyc_cnt <= '0;
                S_WAIT: begin
                    if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
                    if (ru_done) begin
                        resp_valid <= 1'b1;
                        resp_id    <= id_q;
                        resp_addr  <= ru_addr;
                        resp_err   <= 1'b0;
                    end else if (timeout) begin
                        resp_valid <= 1'b1;
                        resp_id    <= id_q;
                        resp_addr  <= '0;
                        resp_err   <= 1'b1;
                    end
                end
                S_DONE: rr_ptr <= ID_W'((int'(id_q) + 1) % NUM_REQ);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rng_address_sched.sv
// Directed bench for rng_address_sched with a behavioural reduction unit attached.
module tb_rng_address_sched;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst;

    // Instance a: MAX_CYCLES=1024, instance b: MAX_CYCLES=8
    logic [3:0]  req_a, req_b;
    logic [63:0] cnt_a, which_a, cnt_b, which_b;
    logic        resp_valid_a, resp_err_a, busy_a, ru_nrst_a, ru_start_a, ru_done_a;
    logic        resp_valid_b, resp_err_b, busy_b, ru_nrst_b, ru_start_b, ru_done_b;
    logic [1:0]  resp_id_a, resp_id_b;
    logic [15:0] resp_addr_a, ru_count_a, ru_which_a, ru_addr_a;
    logic [15:0] resp_addr_b, ru_count_b, ru_which_b, ru_addr_b;

    rng_address_sched #(.NUM_REQ(4), .W(16), .MAX_CYCLES(1024)) dut_a (
        .clock(clock), .rst(rst), .req(req_a), .req_count(cnt_a), .req_which(which_a),
        .resp_valid(resp_valid_a), .resp_id(resp_id_a), .resp_addr(resp_addr_a),
        .resp_err(resp_err_a), .busy(busy_a), .ru_nrst(ru_nrst_a), .ru_start(ru_start_a),
        .ru_count(ru_count_a), .ru_which(ru_which_a), .ru_addr(ru_addr_a), .ru_done(ru_done_a)
    );

    rng_address_sched #(.NUM_REQ(4), .W(16), .MAX_CYCLES(8)) dut_b (
        .clock(clock), .rst(rst), .req(req_b), .req_count(cnt_b), .req_which(which_b),
        .resp_valid(resp_valid_b), .resp_id(resp_id_b), .resp_addr(resp_addr_b),
        .resp_err(resp_err_b), .busy(busy_b), .ru_nrst(ru_nrst_b), .ru_start(ru_start_b),
        .ru_count(ru_count_b), .ru_which(ru_which_b), .ru_addr(ru_addr_b), .ru_done(ru_done_b)
    );

    // Reduction unit: which mod count by repeated subtraction, done latched until nrst.
    logic [15:0] acc_a, acc_b;
    logic        run_a, run_b;

    always @(posedge clock) begin
        if (!ru_nrst_a) begin
            ru_done_a <= 1'b0; run_a <= 1'b0; ru_addr_a <= 16'd0; acc_a <= 16'd0;
        end else if (ru_start_a) begin
            acc_a <= ru_which_a; run_a <= 1'b1;
        end else if (run_a) begin
            if (acc_a < ru_count_a) begin
                ru_addr_a <= acc_a; ru_done_a <= 1'b1; run_a <= 1'b0;
            end else begin
                acc_a <= acc_a - ru_count_a;
            end
        end
    end

    always @(posedge clock) begin
        if (!ru_nrst_b) begin
            ru_done_b <= 1'b0; run_b <= 1'b0; ru_addr_b <= 16'd0; acc_b <= 16'd0;
        end else if (ru_start_b) begin
            acc_b <= ru_which_b; run_b <= 1'b1;
        end else if (run_b) begin
            if (acc_b < ru_count_b) begin
                ru_addr_b <= acc_b; ru_done_b <= 1'b1; run_b <= 1'b0;
            end else begin
                acc_b <= acc_b - ru_count_b;
            end
        end
    end

    int nrst_lo_a = 0;
    int start_a   = 0;
    int resp_cnt_a = 0;
    always @(posedge clock) begin
        if (!rst && !ru_nrst_a) nrst_lo_a <= nrst_lo_a + 1;
        if (ru_start_a)         start_a   <= start_a + 1;
        if (resp_valid_a)       resp_cnt_a <= resp_cnt_a + 1;
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_op(input bit inst, input int id, input int c, input int w);
        if (inst) begin
            cnt_b[id*16 +: 16] = 16'(c); which_b[id*16 +: 16] = 16'(w);
        end else begin
            cnt_a[id*16 +: 16] = 16'(c); which_a[id*16 +: 16] = 16'(w);
        end
    endtask

    // Waits for the response, checks it, then drops req one cycle after the pulse.
    task automatic serve(input bit inst, input int id, input int addr, input int err,
                         input int lat_exp, input bit solo, input string tag);
        int lat;
        lat = 0;
        while (!(inst ? resp_valid_b : resp_valid_a) && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        chk({tag, " valid"},   32'(inst ? resp_valid_b : resp_valid_a), 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(lat_exp));
        chk({tag, " id"},      32'(inst ? resp_id_b : resp_id_a), 32'(id));
        chk({tag, " addr"},    32'(inst ? resp_addr_b : resp_addr_a), 32'(addr));
        chk({tag, " err"},     32'(inst ? resp_err_b : resp_err_a), 32'(err));
        step(2);
        if (solo) chk({tag, " idle after resp"}, 32'(inst ? busy_b : busy_a), 32'd0);
        if (inst) req_b[id[1:0]] = 1'b0;
        else      req_a[id[1:0]] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int snap_n, snap_s, snap_r;

    initial begin
        rst = 1'b1;
        req_a = '0; req_b = '0;
        cnt_a = '0; which_a = '0; cnt_b = '0; which_b = '0;
        step(3);
        chk("rst resp_valid", 32'(resp_valid_a), 32'd0);
        chk("rst resp_id",    32'(resp_id_a),    32'd0);
        chk("rst resp_addr",  32'(resp_addr_a),  32'd0);
        chk("rst resp_err",   32'(resp_err_a),   32'd0);
        chk("rst busy",       32'(busy_a),       32'd0);
        chk("rst ru_start",   32'(ru_start_a),   32'd0);
        chk("rst ru_count",   32'(ru_count_a),   32'd0);
        chk("rst ru_which",   32'(ru_which_a),   32'd0);
        chk("rst ru_nrst",    32'(ru_nrst_a),    32'd0);
        rst = 1'b0;
        step(1);
        chk("post rst ru_nrst", 32'(ru_nrst_a), 32'd1);

        // Test 1: count=3 which=10 -> 1
        snap_n = nrst_lo_a; snap_s = start_a;
        set_op(0, 0, 3, 10); req_a[0] = 1'b1;
        step(1);
        chk("t1 arm nrst",  32'(ru_nrst_a),  32'd0);
        chk("t1 arm busy",  32'(busy_a),     32'd1);
        chk("t1 ru_count",  32'(ru_count_a), 32'd3);
        chk("t1 ru_which",  32'(ru_which_a), 32'd10);
        step(1);
        chk("t1 launch start", 32'(ru_start_a), 32'd1);
        chk("t1 launch nrst",  32'(ru_nrst_a),  32'd1);
        serve(0, 0, 1, 0, 6, 1, "t1");
        chk("t1 nrst low cycles", 32'(nrst_lo_a - snap_n), 32'd1);
        chk("t1 start cycles",    32'(start_a - snap_s),   32'd1);

        // Test 2: which<count, operand change after grant ignored
        set_op(0, 2, 5, 2); req_a[2] = 1'b1;
        step(1);
        set_op(0, 2, 5, 999);
        serve(0, 2, 2, 0, 4, 1, "t2");

        // Test 3: count=0 answered without launching the unit
        snap_n = nrst_lo_a; snap_s = start_a;
        set_op(0, 1, 0, 77); req_a[1] = 1'b1;
        step(1);
        serve(0, 1, 0, 1, 0, 1, "t3");
        chk("t3 no arm",   32'(nrst_lo_a - snap_n), 32'd0);
        chk("t3 no start", 32'(start_a - snap_s),   32'd0);

        // Test 4: timeout with MAX_CYCLES=8, then a normal job on the same unit
        set_op(1, 3, 1, 100); req_b[3] = 1'b1;
        step(1);
        serve(1, 3, 0, 1, 10, 1, "t4 timeout");
        set_op(1, 3, 4, 9); req_b[3] = 1'b1;
        step(1);
        serve(1, 3, 1, 0, 6, 1, "t4 rearm");

        // Test 5: simultaneous requests after a reset that clears the pointer
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_op(0, i, 7, 20);
        req_a = 4'hF;
        step(1);
        serve(0, 0, 6, 0, 6, 0, "t5 r0");
        serve(0, 1, 6, 0, 6, 0, "t5 r1");
        serve(0, 2, 6, 0, 6, 0, "t5 r2");
        serve(0, 3, 6, 0, 6, 1, "t5 r3");
        req_a[0] = 1'b1; req_a[2] = 1'b1;
        step(1);
        serve(0, 0, 6, 0, 6, 0, "t5 again r0");
        serve(0, 2, 6, 0, 6, 1, "t5 again r2");

        // Test 6: reset during WAIT aborts silently; held request re-served
        set_op(0, 0, 2, 51); req_a[0] = 1'b1;
        step(1);
        step(6);
        chk("t6 busy before rst", 32'(busy_a), 32'd1);
        snap_r = resp_cnt_a;
        rst = 1'b1;
        #1;
        chk("t6 nrst during rst", 32'(ru_nrst_a), 32'd0);
        step(1);
        chk("t6 busy after rst",  32'(busy_a),       32'd0);
        chk("t6 no resp",         32'(resp_valid_a), 32'd0);
        rst = 1'b0;
        step(1);
        serve(0, 0, 1, 0, 29, 1, "t6 reserve");
        chk("t6 resp pulses", 32'(resp_cnt_a - snap_r), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
